upg_word_loader: RTL

- Upstream feeder of the instruction-memory programming port.
- Consumes the byte stream from the UART receiver and assembles little-endian 32-bit words.
- Emits one-cycle write strobes with word address and data, and raises done once the declared image is fully written.
- Its outputs drive the program ROM's upg_wen/upg_adr/upg_dat/upg_done inputs directly, and can be shared with the data-memory programming port.

---
 rtl/upg_pkg.sv | 17 +
 rtl/upg_timeout_ctr.sv | 34 +++
 rtl/upg_word_loader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/upg_pkg.sv
// Shared definitions for the programming-port word loader.
package upg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR1,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } upg_state_e;

  localparam int UPG_ADDR_W         = 14;
  localparam int UPG_TIMEOUT_CYCLES = 1000000;
  localparam int UPG_TO_W           = 20;
  localparam int UPG_DEPTH          = 2 ** UPG_ADDR_W;

endpackage

// File: rtl/upg_timeout_ctr.sv
// Clearable saturating idle counter. A clear cycle counts as cycle 0; expire flags
// the cycle after which LIMIT cycles will have elapsed since the last clear.
module upg_timeout_ctr #(
  parameter int LIMIT = 999999,
  parameter int W     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] SAT  = W'(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= ONE;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt != SAT) begin
      cnt <= cnt + ONE;
    end
  end

  assign expire = en && !clr && (cnt == LAST);

endmodule

// File: rtl/upg_word_loader.sv
// Assembles little-endian 32-bit words from a UART byte stream (16-bit word count
// header first) and drives the program-memory write port.
module upg_word_loader
  import upg_pkg::*;
#(
  parameter int ADDR_W         = UPG_ADDR_W,
  parameter int TIMEOUT_CYCLES = UPG_TIMEOUT_CYCLES,
  parameter int TO_W           = UPG_TO_W
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_byte_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              upg_err_o,
  output logic              busy_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IW    = ADDR_W + 1;

  upg_state_e    state;
  logic [7:0]    cnt_lo;
  logic [IW-1:0] n_words;
  logic [IW-1:0] word_idx;
  logic [IW-1:0] word_idx_inc;
  logic [1:0]    byte_idx;
  logic [23:0]   word_q;
  logic [15:0]   n_hdr;
  logic          to_en;
  logic          to_clr;
  logic          to_expire;

  assign n_hdr        = {rx_byte_i, cnt_lo};
  assign word_idx_inc = word_idx + IW'(1);
  assign to_en        = (state == ST_HDR1) || (state == ST_DATA);
  assign to_clr       = rx_valid_i && ((state == ST_IDLE) || to_en);

  upg_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES - 1),
    .W     (TO_W)
  ) u_timeout (
    .clk    (upg_clk_i),
    .rst    (upg_rst_i),
    .en     (to_en),
    .clr    (to_clr),
    .expire (to_expire)
  );

  always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
    if (upg_rst_i) begin
      state      <= ST_IDLE;
      cnt_lo     <= '0;
      n_words    <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      word_q     <= '0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b0;
      upg_err_o  <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      upg_wen_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (rx_valid_i) begin
            cnt_lo <= rx_byte_i;
            busy_o <= 1'b1;
            state  <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (rx_valid_i) begin
            word_idx <= '0;
            byte_idx <= '0;
            if (n_hdr == 16'd0) begin
              busy_o <= 1'b0;
              state  <= ST_DONE;
            end else if ({16'd0, n_hdr} > 32'(DEPTH)) begin
              busy_o    <= 1'b0;
              upg_err_o <= 1'b1;
              state     <= ST_ERR;
            end else begin
              n_words <= IW'(n_hdr);
              state   <= ST_DATA;
            end
          end else if (to_expire) begin
            busy_o    <= 1'b0;
            upg_err_o <= 1'b1;
            state     <= ST_ERR;
          end
        end
        ST_DATA: begin
          if (rx_valid_i) begin
            byte_idx <= byte_idx + 2'd1;
            unique case (byte_idx)
              2'd0: word_q[7:0]   <= rx_byte_i;
              2'd1: word_q[15:8]  <= rx_byte_i;
              2'd2: word_q[23:16] <= rx_byte_i;
              default: begin
                // Lane 3 goes straight to the port so wen lands one cycle after the byte.
                upg_wen_o <= 1'b1;
                upg_adr_o <= word_idx[ADDR_W-1:0];
                upg_dat_o <= {rx_byte_i, word_q};
                word_idx  <= word_idx_inc;
                if (word_idx_inc == n_words) begin
                  busy_o <= 1'b0;
                  state  <= ST_DONE;
                end
              end
            endcase
          end else if (to_expire) begin
            busy_o    <= 1'b0;
            upg_err_o <= 1'b1;
            state     <= ST_ERR;
          end
        end
        ST_DONE: begin
          // Raised one cycle after entry so done never overlaps the final write.
          upg_done_o <= 1'b1;
        end
        ST_ERR: begin
          upg_err_o <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
